// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell modulo counter: the {J,K} pin encodings
// and the helper that derives the pin pair for a cell from its current and
// next state.
package jk_pkg;

  // {J,K} encodings as seen at a JK flip-flop cell
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Drive a cell so it lands on n from q using only hold/set/reset.
  // A 0->1 move raises J, a 1->0 move raises K, otherwise both stay low,
  // so the toggle code can never be produced.
  function automatic logic [1:0] jk_drive(input logic q, input logic n);
    return {~q & n, q & ~n};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with asynchronous active-low reset to Q=0.
// Provides both Q and Qn.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  // Classic JK characteristic: hold, reset, set or toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter built from WIDTH JK cells.
// Next-state and modulus logic run in WIDTH+1 bits; each cell is steered to
// the next count through its J/K pins, and the cells' Q outputs are the count.
// Optional build macro JK_MOD_COUNTER_SAT_EN selects saturating mode: the
// count sticks at the ends and wrap flags the first blocked step instead of
// a wrap-around. MODULUS must lie in 2..2**WIDTH.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam int               W1     = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_N  = W1'(MODULUS);
  localparam logic [WIDTH:0]   MOD_M1 = W1'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH:0]   next_ext;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] qn_vec;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             q_is_zero;
  logic             wrap_next;

  assign q_ext     = {1'b0, count};
  assign lv_ext    = {1'b0, load_val};
  // All cells cleared: read straight from the complementary outputs
  assign q_is_zero = &qn_vec;

`ifdef JK_MOD_COUNTER_SAT_EN
  logic blocked;
  logic blk_reg;
  logic blk_next;

  // Saturating next state; wrap only on the first of a run of blocked steps
  always_comb begin
    next_ext  = q_ext;
    blocked   = 1'b0;
    blk_next  = blk_reg;
    wrap_next = 1'b0;
    if (load) begin
      next_ext = (lv_ext < MOD_N) ? lv_ext : MOD_M1;
      blk_next = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        if (q_ext >= MOD_M1) begin
          next_ext = MOD_M1;
          blocked  = (q_ext == MOD_M1);
        end else begin
          next_ext = q_ext + W1'(1);
        end
      end else begin
        if (q_ext >= MOD_N) begin
          next_ext = MOD_M1;
        end else if (q_is_zero) begin
          next_ext = '0;
          blocked  = 1'b1;
        end else begin
          next_ext = q_ext - W1'(1);
        end
      end
      blk_next  = blocked;
      wrap_next = blocked & ~blk_reg;
    end
  end

  // Remembers that the previous enabled step was already blocked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blk_reg <= 1'b0;
    else          blk_reg <= blk_next;
  end
`else
  // Wrap-around next state with recovery from out-of-range counts
  always_comb begin
    next_ext  = q_ext;
    wrap_next = 1'b0;
    if (load) begin
      next_ext = (lv_ext < MOD_N) ? lv_ext : MOD_M1;
    end else if (en) begin
      if (up_dn) begin
        if (q_ext >= MOD_M1) begin
          next_ext  = '0;
          wrap_next = (q_ext == MOD_M1);
        end else begin
          next_ext = q_ext + W1'(1);
        end
      end else begin
        if (q_ext >= MOD_N) begin
          next_ext = MOD_M1;
        end else if (q_is_zero) begin
          next_ext  = MOD_M1;
          wrap_next = 1'b1;
        end else begin
          next_ext = q_ext - W1'(1);
        end
      end
    end
  end
`endif

  assign next_count = next_ext[WIDTH-1:0];

  // One JK cell per bit, driven toward the next count
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign {j_vec[gi], k_vec[gi]} = jk_drive(count[gi], next_count[gi]);

      jk_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .j       (j_vec[gi]),
        .k       (k_vec[gi]),
        .q       (count[gi]),
        .qn      (qn_vec[gi])
      );
    end
  endgenerate

  // Registered terminal-count / blocked-step pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap <= 1'b0;
    else          wrap <= wrap_next;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter (WIDTH=4, MODULUS=10). A behavioural model tracks
// the count with modular arithmetic; a compare process checks count, wrap and
// the no-toggle property every falling edge, and directed sequences pin the
// model with literal expectations. Define JK_MOD_COUNTER_SAT_EN for the
// saturating-mode sequences.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_count = 0;
  int m_wrap  = 0;
  int m_blk   = 0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model from the counting rules
  always @(posedge clk or negedge reset_n) begin
    int old;
    if (!reset_n) begin
      m_count = 0;
      m_wrap  = 0;
      m_blk   = 0;
    end else begin
      old = m_count;
      if (load) begin
        m_count = (int'(load_val) < M) ? int'(load_val) : M - 1;
        m_wrap  = 0;
        m_blk   = 0;
      end else if (en) begin
`ifdef JK_MOD_COUNTER_SAT_EN
        int blocked;
        blocked = up_dn ? (old == M - 1) : (old == 0);
        if (!blocked) m_count = up_dn ? old + 1 : old - 1;
        m_wrap = (blocked && !m_blk) ? 1 : 0;
        m_blk  = blocked;
`else
        m_count = up_dn ? (old + 1) % M : (old + M - 1) % M;
        m_wrap  = up_dn ? int'(old == M - 1) : int'(old == 0);
`endif
      end else begin
        m_wrap = 0;
      end
    end
  end

  // Compare process: every falling edge
  always @(negedge clk) begin
    chk("count", int'(count), m_count);
    chk("wrap", int'(wrap), m_wrap);
    chk("no_toggle", int'(dut.j_vec & dut.k_vec), 0);
  end

  // Apply one set of inputs across one rising edge; return at the next falling edge
  task automatic step(input logic e, input logic ud, input logic ld, input int lv);
    en       = e;
    up_dn    = ud;
    load     = ld;
    load_val = W'(lv);
    @(posedge clk);
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
  endtask

  initial begin
`ifndef JK_MOD_COUNTER_SAT_EN
    int exp_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_upw[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_dn[3]   = '{9, 8, 7};
    int exp_dnw[3]  = '{1, 0, 0};
`endif
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_wrap", int'(wrap), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset mid-count
    step(1'b0, 1'b1, 1'b1, 7);
    chk("load7", int'(count), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", int'(count), 0);
    en = 1'b0;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 0);
    chk("first_after_rst", int'(count), 1);

    // Load range handling and priority
    step(1'b0, 1'b1, 1'b1, 9);
    step(1'b1, 1'b1, 1'b1, 5);
    chk("load_over_en", int'(count), 5);
    chk("load_wrap0", int'(wrap), 0);
    step(1'b0, 1'b1, 1'b1, 13);
    chk("load13", int'(count), 9);
    step(1'b0, 1'b0, 1'b1, 15);
    chk("load15", int'(count), 9);

    // Hold
    step(1'b0, 1'b1, 1'b1, 6);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      chk("hold", int'(count), 6);
    end

    // Direction change with no dead cycle
    step(1'b1, 1'b1, 1'b0, 0);
    chk("dir_up", int'(count), 7);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("dir_dn", int'(count), 6);

`ifndef JK_MOD_COUNTER_SAT_EN
    // Up wrap
    step(1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 0);
      chk("up_seq", int'(count), exp_up[i]);
      chk("up_wrap", int'(wrap), exp_upw[i]);
    end
    // Down wrap
    step(1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 0);
      chk("dn_seq", int'(count), exp_dn[i]);
      chk("dn_wrap", int'(wrap), exp_dnw[i]);
    end
`else
    // Saturating up: 8 -> 9,9,9 with a single pulse
    step(1'b0, 1'b1, 1'b1, 8);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("sat_up0", int'(count), 9);
    chk("sat_up0_w", int'(wrap), 0);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("sat_up1", int'(count), 9);
    chk("sat_up1_w", int'(wrap), 1);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("sat_up2", int'(count), 9);
    chk("sat_up2_w", int'(wrap), 0);
    // Saturating down: 1 -> 0,0 with a single pulse
    step(1'b0, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("sat_dn0", int'(count), 0);
    chk("sat_dn0_w", int'(wrap), 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("sat_dn1", int'(count), 0);
    chk("sat_dn1_w", int'(wrap), 1);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("sat_dn2_w", int'(wrap), 0);
`endif

    // Full up and down sweeps; no-toggle checked every cycle by the compare process
    for (int i = 0; i < 2 * M; i++) step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2 * M; i++) step(1'b1, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
